mio_bus_master: RTL and testbench

- CPU-side initiator for the MIO peripheral bus; the address decoder is the responder on the other end.
- Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake.
- Drives word-only bus signals `addr_bus`, `Cpu_data2bus` and `mem_w`, and samples `Cpu_data4bus`.
- Handles byte and halfword accesses: sub-word loads are extracted and sign/zero-extended; sub-word stores use a read-modify-write; misaligned requests are flagged.

---
 rtl/mio_bus_master_pkg.sv | 38 +++
 rtl/mio_lane_align.sv | 55 +++++
 rtl/mio_bus_master.sv | 191 +++++++++++++++++++
 tb/tb_mio_bus_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mio_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mio_bus_master_pkg
// Description : Shared types and constants for the MIO bus master. Contains
//               the request size encodings, the FSM state encoding and the
//               read-latency counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mio_bus_master_pkg;

  // Request size encodings, as carried on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int DEFAULT_READ_LATENCY = 1;

  // Width of a down-counter that must hold the value lat.
  // The result is never below 1, so a zero-latency build still has a legal vector.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(DEFAULT_READ_LATENCY);

endpackage : mio_bus_master_pkg
`default_nettype wire

// File: rtl/mio_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mio_lane_align
// Description : Combinational little-endian lane logic. For loads it extracts
//               the addressed byte/half and sign- or zero-extends it. For
//               stores it merges the new byte/half into the word read from the
//               bus, so the surrounding lanes are written back unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module mio_lane_align
  import mio_bus_master_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext_b;
  logic        sext_h;

  // Select the addressed lanes, then extend the load or merge the store.
  always_comb begin
    byte_sel   = word[{addr_lo, 3'b000} +: 8];
    half_sel   = word[{addr_lo[1], 4'b0000} +: 16];
    sext_b     = ~is_unsigned & byte_sel[7];
    sext_h     = ~is_unsigned & half_sel[15];
    load_data  = word;
    store_data = wdata;
    case (size_e'(size))
      SZ_BYTE: begin
        load_data  = {{24{sext_b}}, byte_sel};
        store_data = word;
        store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{sext_h}}, half_sel};
        store_data = word;
        store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        // Word (and the never-issued illegal size) pass straight through.
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule : mio_lane_align
`default_nettype wire

// File: rtl/mio_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mio_bus_master
// Description : CPU-side initiator for the MIO peripheral bus. Takes one
//               load/store at a time from the MEM stage, drives the word-only
//               bus, and returns a one-cycle response. Sub-word stores are done
//               as read-modify-write; misaligned and illegal-size requests are
//               answered with an error and never reach the bus.
//               Optional macro MIO_BUS_MASTER_PERF_EN adds the perf_loads,
//               perf_stores and perf_busy counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mio_bus_master
  import mio_bus_master_pkg::*;
#(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_bus,
  output logic [31:0] Cpu_data2bus,
  output logic        mem_w,
  input  logic [31:0] Cpu_data4bus
`ifdef MIO_BUS_MASTER_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_busy
`endif
);

  localparam int            CNT_W    = cnt_width(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RD   = RD;
  localparam logic [1:0] S_WR   = WR;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [1:0]       lat_size;
  logic             lat_uns;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [31:0]      rd_word;

  logic             req_bad;
  logic [31:0]      align_word;
  logic [31:0]      load_data;
  logic [31:0]      store_data;
  logic [31:0]      word_addr;

  // Decode alignment and size legality straight from the live request.
  always_comb begin
    req_bad = 1'b0;
    case (size_e'(req_size))
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = |req_addr[1:0];
      SZ_ILL:  req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  // The load path works on the live bus data so the result is ready on the
  // capture edge; the store merge works on the word captured at the end of RD.
  assign align_word = (state == S_WR) ? rd_word : Cpu_data4bus;
  assign word_addr  = {lat_addr[31:2], 2'b00};

  mio_lane_align u_align (
    .addr_lo     (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_uns),
    .word        (align_word),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  // Request FSM: latch on accept, count the read window, write once, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_uns    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rd_word    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            if (req_bad) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              state      <= S_RESP;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cnt == '0) begin
            rd_word <= Cpu_data4bus;
            if (lat_we) begin
              state <= S_WR;
            end else begin
              resp_rdata <= load_data;
              resp_err   <= 1'b0;
              state      <= S_RESP;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= S_RESP;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus outputs are decoded from state so reset clears them immediately.
  always_comb begin
    addr_bus     = '0;
    Cpu_data2bus = '0;
    mem_w        = 1'b0;
    if (state == S_RD) begin
      addr_bus = word_addr;
    end else if (state == S_WR) begin
      addr_bus     = word_addr;
      Cpu_data2bus = store_data;
      mem_w        = 1'b1;
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

`ifdef MIO_BUS_MASTER_PERF_EN
  // Free-running wrap-around activity counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_busy   <= '0;
    end else begin
      if (state != S_IDLE) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if ((state == S_RESP) && !resp_err) begin
        if (lat_we) begin
          perf_stores <= perf_stores + 32'd1;
        end else begin
          perf_loads <= perf_loads + 32'd1;
        end
      end
    end
  end
`endif

endmodule : mio_bus_master
`default_nettype wire

// File: tb/tb_mio_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mio_bus_master
// Description : Directed self-checking bench for mio_bus_master with the
//               default read latency of one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mio_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_bus;
  logic [31:0] Cpu_data2bus;
  logic        mem_w;
  logic [31:0] Cpu_data4bus;
  logic [31:0] bus_word = '0;
`ifdef MIO_BUS_MASTER_PERF_EN
  logic [31:0] perf_loads;
  logic [31:0] perf_stores;
  logic [31:0] perf_busy;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prev_rdata = '0;
  logic        prev_err   = 1'b0;
  int          exp_loads  = 0;
  int          exp_stores = 0;
  int          exp_busy   = 0;

  assign Cpu_data4bus = bus_word;

  always #5 clk = ~clk;

  mio_bus_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .addr_bus     (addr_bus),
    .Cpu_data2bus (Cpu_data2bus),
    .mem_w        (mem_w),
    .Cpu_data4bus (Cpu_data4bus)
`ifdef MIO_BUS_MASTER_PERF_EN
    ,
    .perf_loads   (perf_loads),
    .perf_stores  (perf_stores),
    .perf_busy    (perf_busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request in the IDLE cycle, then watch the bus until the response.
  task automatic run_test(input string name, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] bus, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata);
    int          lat = 0;
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          ready_hi = 0;
    int          bad = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rdata = '0;
    logic        err = 1'b0;
    bus_word = bus;
    @(negedge clk);
    check({name, "/ready"}, {31'd0, req_ready}, 32'd1);
    check({name, "/held"}, {resp_valid, resp_err, resp_rdata[29:0]},
          {1'b0, prev_err, prev_rdata[29:0]});
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble the request inputs; the DUT must work from its latched copy.
    req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (req_ready) ready_hi++;
      if (mem_w) begin
        wr_cyc++;
        wr_addr = addr_bus;
        wr_data = Cpu_data2bus;
      end else begin
        if (addr_bus != 32'd0) begin
          rd_cyc++;
          if (addr_bus != {addr[31:2], 2'b00}) bad++;
        end
        if (Cpu_data2bus != 32'd0) bad++;
      end
      if (resp_valid) begin
        lat   = k;
        rdata = resp_rdata;
        err   = resp_err;
      end
    end
    check({name, "/latency"}, 32'(lat), 32'(exp_lat));
    check({name, "/rdata"}, rdata, exp_rdata);
    check({name, "/err"}, {31'd0, err}, {31'd0, exp_err});
    check({name, "/rd_cycles"}, 32'(rd_cyc), 32'(exp_rd));
    check({name, "/wr_cycles"}, 32'(wr_cyc), 32'(exp_wr));
    check({name, "/ready_low"}, 32'(ready_hi + bad), 32'd0);
    if (exp_wr != 0) begin
      check({name, "/wr_addr"}, wr_addr, {addr[31:2], 2'b00});
      check({name, "/wr_data"}, wr_data, exp_wdata);
    end
    prev_rdata = exp_rdata;
    prev_err   = exp_err;
    exp_busy  += exp_lat;
    if (!exp_err) begin
      if (we) exp_stores++;
      else    exp_loads++;
    end
  endtask

  initial begin
    int saw_wr;
    int saw_resp;
    repeat (2) @(negedge clk);
    check("reset/ready", {31'd0, req_ready}, 32'd1);
    check("reset/outs", {29'd0, resp_valid, resp_err, mem_w}, 32'd0);
    check("reset/addr_bus", addr_bus, 32'd0);
    check("reset/data2bus", Cpu_data2bus, 32'd0);
    check("reset/rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    //        name      we    sz     uns   addr          wdata          bus            lat rdata          err  rd wr wdata
    run_test("wload",   1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0);
    run_test("lb_s",    1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h80FF_1234, 3, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h0);
    run_test("lb_u",    1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'h80FF_1234, 3, 32'h0000_0080, 1'b0, 2, 0, 32'h0);
    run_test("lh_s",    1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'h80FF_1234, 3, 32'hFFFF_80FF, 1'b0, 2, 0, 32'h0);
    run_test("lh_u",    1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h80FF_1234, 3, 32'h0000_80FF, 1'b0, 2, 0, 32'h0);
    run_test("lb_s1",   1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'h80FF_1234, 3, 32'h0000_0012, 1'b0, 2, 0, 32'h0);
    run_test("lb_s2",   1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,         32'h80FF_1234, 3, 32'hFFFF_FFFF, 1'b0, 2, 0, 32'h0);
    run_test("lw_u",    1'b0, 2'b10, 1'b1, 32'h0000_0014, 32'h0,         32'h80FF_1234, 3, 32'h80FF_1234, 1'b0, 2, 0, 32'h0);
    run_test("sh",      1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 32'h1122_3344, 4, 32'h0,         1'b0, 2, 1, 32'hABCD_3344);
    run_test("sb",      1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h1234_565A, 32'h1122_3344, 4, 32'h0,         1'b0, 2, 1, 32'h1122_5A44);
    run_test("sh_lo",   1'b1, 2'b01, 1'b0, 32'h0000_0020, 32'hFFFF_BEEF, 32'h1122_3344, 4, 32'h0,         1'b0, 2, 1, 32'h1122_BEEF);
    run_test("sw",      1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         2, 32'h0,         1'b0, 0, 1, 32'hCAFE_F00D);
    run_test("lw_b2b",  1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0, 2, 0, 32'h0);
    run_test("mis_lw",  1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         32'h1357_9BDF, 1, 32'h0,         1'b1, 0, 0, 32'h0);
    run_test("mis_sh",  1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_1234, 32'h1357_9BDF, 1, 32'h0,         1'b1, 0, 0, 32'h0);
    run_test("ill_sz",  1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,         32'h1357_9BDF, 1, 32'h0,         1'b1, 0, 0, 32'h0);
    run_test("lb_post", 1'b0, 2'b00, 1'b1, 32'h0000_0015, 32'h0,         32'h0000_A500, 3, 32'h0000_00A5, 1'b0, 2, 0, 32'h0);

`ifdef MIO_BUS_MASTER_PERF_EN
    @(negedge clk);
    check("perf/loads", perf_loads, 32'(exp_loads));
    check("perf/stores", perf_stores, 32'(exp_stores));
    check("perf/busy", perf_busy, 32'(exp_busy));
`endif

    // Reset while a sub-word store is in its write cycle.
    bus_word = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h0000_0022; req_wdata = 32'h0000_1111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    saw_wr = 0;
    for (int k = 0; k < 10 && saw_wr == 0; k++) begin
      @(negedge clk);
      if (mem_w) saw_wr = 1;
    end
    check("rst/saw_wr", 32'(saw_wr), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst/mem_w_async", {31'd0, mem_w}, 32'd0);
    check("rst/addr_async", addr_bus, 32'd0);
    check("rst/data_async", Cpu_data2bus, 32'd0);
    saw_resp = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid) saw_resp++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) saw_resp++;
    end
    check("rst/no_resp", 32'(saw_resp), 32'd0);
    check("rst/ready", {31'd0, req_ready}, 32'd1);
    check("rst/rdata", {resp_err, resp_rdata[30:0]}, 32'd0);
`ifdef MIO_BUS_MASTER_PERF_EN
    check("rst/perf", perf_loads | perf_stores | perf_busy, 32'd0);
`endif
    prev_rdata = '0;
    prev_err   = 1'b0;
    run_test("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1'b0, 2, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mio_bus_master
`default_nettype wire
